// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file.
//   - Default width constants for data and address.
//   - Clear-sweep FSM state encodings (StIdle, StClear).
//   - slice_offset(): bit offset of a port within a packed multi-port bus.
package regfile_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 5;

  // Clear-sweep FSM states; kept as plain constants so older tools can use them.
  typedef logic [0:0] state_t;
  localparam state_t StIdle  = 1'b0;
  localparam state_t StClear = 1'b1;

  function automatic int unsigned slice_offset(input int unsigned port,
                                               input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer for the register file.
// Sweeps every entry once, one entry per cycle, starting at index 0.
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset.
//   clear_req    - pulse that starts a sweep; ignored while a sweep runs.
//   clear_busy   - high for exactly 2**ADDR_W cycles while the sweep runs.
//   clear_done   - one-cycle pulse after the final entry has been zeroed.
//   clear_we     - zero-write strobe to the storage array.
//   clear_addr   - entry to zero when clear_we is high.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr
);

  localparam logic [ADDR_W-1:0] LastIdx = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          index_d = '0;
        end
      end
      StClear: begin
        // Final entry ends the sweep; the index is parked at 0 so it never wraps
        // into a second pass.
        if (index_q == LastIdx) begin
          state_d = StIdle;
          index_d = '0;
          done_d  = 1'b1;
        end else begin
          index_d = index_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      index_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      done_q  <= done_d;
    end
  end

  assign clear_busy = (state_q == StClear);
  assign clear_done = done_q;
  assign clear_we   = clear_busy;
  assign clear_addr = index_q;

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: 2**ADDR_W x DATA_W storage, NUM_RD combinational read
// ports, one synchronous write port and a sequential bulk-clear engine.
// Ports:
//   clk, reset_n - clock and asynchronous active-low reset (zeroes all entries).
//   rd_addr      - packed read addresses, port k at [k*ADDR_W +: ADDR_W].
//   rd_data      - packed read data, port k at [k*DATA_W +: DATA_W].
//   wr_en, wr_addr, wr_data - write port; writes are dropped while clearing.
//   clear_req, clear_busy, clear_done - bulk-clear handshake.
// Optional build macro:
//   REGFILE_BYPASS_EN - forward an accepted write to matching read ports in the
//                       same cycle (never for entry 0 when ZERO_REG is set).
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     clear_done
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam bit          HasZeroReg = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [Depth];
  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;
  logic              wr_accept;
  logic              wr_commit;

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  // Writes are only taken while the sweep is idle; busy writes are simply lost.
  assign wr_accept = wr_en & ~clear_busy;
  assign wr_commit = wr_accept & ~(HasZeroReg && (wr_addr == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_we) begin
      mem_q[clear_addr] <= '0;
    end else if (wr_commit) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[slice_offset(k, ADDR_W) +: ADDR_W];

    always_comb begin
      data = mem_q[addr];
      if (HasZeroReg && (addr == '0)) begin
        data = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_accept && (addr == wr_addr)) begin
        data = wr_data;
`endif
      end
    end

    assign rd_data[slice_offset(k, DATA_W) +: DATA_W] = data;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: default 32x32 / 2-port instance plus
// an 8x16 / 4-port instance. Expected read data is queued when a read is set up
// and popped when the outputs are sampled.
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;
  localparam int PDW = 16;
  localparam int PAW = 3;
  localparam int PNR = 4;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n;
  logic [NR*AW-1:0]    rd_addr;
  logic [NR*DW-1:0]    rd_data;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic                clear_req;
  logic                clear_busy;
  logic                clear_done;

  logic [PNR*PAW-1:0]  p_rd_addr;
  logic [PNR*PDW-1:0]  p_rd_data;
  logic                p_wr_en;
  logic [PAW-1:0]      p_wr_addr;
  logic [PDW-1:0]      p_wr_data;
  logic                p_clear_req;
  logic                p_clear_busy;
  logic                p_clear_done;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];

  regfile_multiport dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done)
  );

  regfile_multiport #(
    .DATA_W   (PDW),
    .ADDR_W   (PAW),
    .NUM_RD   (PNR),
    .ZERO_REG (1)
  ) dut_p (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_addr    (p_rd_addr),
    .rd_data    (p_rd_data),
    .wr_en      (p_wr_en),
    .wr_addr    (p_wr_addr),
    .wr_data    (p_wr_data),
    .clear_req  (p_clear_req),
    .clear_busy (p_clear_busy),
    .clear_done (p_clear_done)
  );

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a != '0) model[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b done=%b want 0 0", clear_busy, clear_done);
    end
    rd_addr = {5'd31, 5'd5};
    exp_q.push_back('0); exp_q.push_back('0);
    #1;
    for (int k = 0; k < NR; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[k*DW +: DW] !== e) begin
        failures++;
        $display("FAIL reset_in port%0d: got %h want %h", k, rd_data[k*DW +: DW], e);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    wr(5'd5, 32'hDEADBEEF);
    rd_addr = {5'd5, 5'd5};
    exp_q.push_back(model[5]); exp_q.push_back(model[5]);
    #1;
    for (int k = 0; k < NR; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[k*DW +: DW] !== e) begin
        failures++;
        $display("FAIL preload port%0d: got %h want %h", k, rd_data[k*DW +: DW], e);
      end
    end
    // Asynchronous reset asserted between clock edges.
    @(posedge clk);
    #2 reset_n = 1'b0;
    model_clear();
    exp_q.push_back('0); exp_q.push_back('0);
    #1;
    for (int k = 0; k < NR; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[k*DW +: DW] !== e) begin
        failures++;
        $display("FAIL async_reset port%0d: got %h want %h", k, rd_data[k*DW +: DW], e);
      end
    end
    checks++;
    if (clear_busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_busy: got %b want 0", clear_busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    wr(5'd3, 32'h12345678);
    rd_addr = {5'd3, 5'd3};
    exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678);
    #1;
    for (int k = 0; k < NR; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[k*DW +: DW] !== e) begin
        failures++;
        $display("FAIL write_read port%0d: got %h want %h", k, rd_data[k*DW +: DW], e);
      end
    end
    wr(5'd0, 32'hFFFFFFFF);
    rd_addr = {5'd3, 5'd0};
    exp_q.push_back(32'h0); exp_q.push_back(32'h12345678);
    #1;
    for (int k = 0; k < NR; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[k*DW +: DW] !== e) begin
        failures++;
        $display("FAIL zero_reg port%0d: got %h want %h", k, rd_data[k*DW +: DW], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] vals [3];
    addrs = '{5'd10, 5'd11, 5'd12};
    vals = '{32'hA0A0A0A0, 32'h0B0B0B0B, 32'hC0FFEE00};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_addr = addrs[i];
      wr_data = vals[i];
      model[addrs[i]] = vals[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_addr = {addrs[(i + 1) % 3], addrs[i]};
      exp_q.push_back(model[addrs[i]]);
      exp_q.push_back(model[addrs[(i + 1) % 3]]);
      #1;
      for (int k = 0; k < NR; k++) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (rd_data[k*DW +: DW] !== e) begin
          failures++;
          $display("FAIL back_to_back i%0d port%0d: got %h want %h", i, k,
                   rd_data[k*DW +: DW], e);
        end
      end
    end
  endtask

  task automatic test_bulk_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = 0;
    for (int i = 1; i < DEPTH; i++) wr(AW'(i), DW'(i));
    // Write issued together with clear_req is still performed.
    @(negedge clk);
    clear_req = 1'b1;
    wr_en = 1'b1;
    wr_addr = 5'd25;
    wr_data = 32'h77;
    model[25] = 32'h77;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      clear_req = 1'b0;
      wr_en = 1'b0;
      if (clear_busy === 1'b1) busy_cnt++;
      if (clear_done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (c == 10) begin
        // Entries 0..8 have been swept by now; 9 and up still hold old data.
        rd_addr = {5'd25, 5'd8};
        exp_q.push_back(32'h0); exp_q.push_back(32'h77);
        #1;
        for (int k = 0; k < NR; k++) begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          checks++;
          if (rd_data[k*DW +: DW] !== e) begin
            failures++;
            $display("FAIL partial_a port%0d: got %h want %h", k, rd_data[k*DW +: DW], e);
          end
        end
        rd_addr = {5'd20, 5'd9};
        exp_q.push_back(32'd9); exp_q.push_back(32'd20);
        #1;
        for (int k = 0; k < NR; k++) begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          checks++;
          if (rd_data[k*DW +: DW] !== e) begin
            failures++;
            $display("FAIL partial_b port%0d: got %h want %h", k, rd_data[k*DW +: DW], e);
          end
        end
      end
      if (c == 5) clear_req = 1'b1;
      if (c == 20) begin
        wr_en = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'hBAD0BAD0;
      end
    end
    model_clear();
    checks++;
    if (busy_cnt != DEPTH) begin
      failures++;
      $display("FAIL clear_busy_len: got %0d want %0d", busy_cnt, DEPTH);
    end
    checks++;
    if (done_cnt != 1 || done_at != DEPTH + 1) begin
      failures++;
      $display("FAIL clear_done: got count %0d at %0d want 1 at %0d", done_cnt, done_at,
               DEPTH + 1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = {AW'(DEPTH - 1 - i), AW'(i)};
      exp_q.push_back(model[i]); exp_q.push_back(model[DEPTH - 1 - i]);
      #1;
      for (int k = 0; k < NR; k++) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (rd_data[k*DW +: DW] !== e) begin
          failures++;
          $display("FAIL cleared r%0d port%0d: got %h want %h", i, k, rd_data[k*DW +: DW], e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int done_cnt = 0;
    int busy_cnt = 0;
    wr(5'd9, 32'h99);
    wr(5'd20, 32'h20);
    wr(5'd30, 32'h30);
    @(negedge clk);
    clear_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      clear_req = 1'b0;
    end
    #2 reset_n = 1'b0;
    model_clear();
    rd_addr = {5'd30, 5'd20};
    exp_q.push_back(model[20]); exp_q.push_back(model[30]);
    #1;
    for (int k = 0; k < NR; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[k*DW +: DW] !== e) begin
        failures++;
        $display("FAIL mid_reset port%0d: got %h want %h", k, rd_data[k*DW +: DW], e);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (clear_done === 1'b1) done_cnt++;
      if (clear_busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (done_cnt != 0 || busy_cnt != 0) begin
      failures++;
      $display("FAIL abort_sweep: done %0d busy %0d want 0 0", done_cnt, busy_cnt);
    end
    wr(5'd9, 32'hA5);
    rd_addr = {5'd20, 5'd9};
    exp_q.push_back(model[9]); exp_q.push_back(model[20]);
    #1;
    for (int k = 0; k < NR; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[k*DW +: DW] !== e) begin
        failures++;
        $display("FAIL post_reset port%0d: got %h want %h", k, rd_data[k*DW +: DW], e);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 5'd4;
    wr_data = 32'h55;
    rd_addr = {5'd0, 5'd4};
    exp_q.push_back(Bypass ? 32'h55 : model[4]); exp_q.push_back(32'h0);
    #1;
    for (int k = 0; k < NR; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[k*DW +: DW] !== e) begin
        failures++;
        $display("FAIL bypass_same port%0d: got %h want %h", k, rd_data[k*DW +: DW], e);
      end
    end
    model[4] = 32'h55;
    @(negedge clk);
    wr_addr = 5'd0;
    wr_data = 32'hFFFF;
    rd_addr = {5'd4, 5'd0};
    exp_q.push_back(32'h0); exp_q.push_back(model[4]);
    #1;
    for (int k = 0; k < NR; k++) begin
      logic [DW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rd_data[k*DW +: DW] !== e) begin
        failures++;
        $display("FAIL bypass_next port%0d: got %h want %h", k, rd_data[k*DW +: DW], e);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_param();
    logic [PDW-1:0] pexp [$];
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = 0;
    @(negedge clk);
    p_wr_en = 1'b1;
    p_wr_addr = 3'd2;
    p_wr_data = 16'hBEEF;
    @(negedge clk);
    p_wr_addr = 3'd6;
    p_wr_data = 16'h0042;
    @(negedge clk);
    p_wr_en = 1'b0;
    p_rd_addr = {3'd2, 3'd0, 3'd6, 3'd2};
    pexp.push_back(16'hBEEF); pexp.push_back(16'h0042);
    pexp.push_back(16'h0000); pexp.push_back(16'hBEEF);
    #1;
    for (int k = 0; k < PNR; k++) begin
      logic [PDW-1:0] e;
      e = pexp.pop_front();
      checks++;
      if (p_rd_data[k*PDW +: PDW] !== e) begin
        failures++;
        $display("FAIL param_read port%0d: got %h want %h", k, p_rd_data[k*PDW +: PDW], e);
      end
    end
    @(negedge clk);
    p_clear_req = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      p_clear_req = 1'b0;
      if (p_clear_busy === 1'b1) busy_cnt++;
      if (p_clear_done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
    end
    checks++;
    if (busy_cnt != 8 || done_cnt != 1 || done_at != 9) begin
      failures++;
      $display("FAIL param_clear: busy %0d done %0d at %0d want 8 1 at 9", busy_cnt,
               done_cnt, done_at);
    end
    pexp.push_back('0); pexp.push_back('0); pexp.push_back('0); pexp.push_back('0);
    #1;
    for (int k = 0; k < PNR; k++) begin
      logic [PDW-1:0] e;
      e = pexp.pop_front();
      checks++;
      if (p_rd_data[k*PDW +: PDW] !== e) begin
        failures++;
        $display("FAIL param_cleared port%0d: got %h want %h", k, p_rd_data[k*PDW +: PDW], e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    rd_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clear_req = 1'b0;
    p_rd_addr = '0;
    p_wr_en = 1'b0;
    p_wr_addr = '0;
    p_wr_data = '0;
    p_clear_req = 1'b0;
    model_clear();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_bulk_clear();
    test_reset_mid_sweep();
    test_bypass();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
